// File: rtl/gate_exerciser.sv
// Exhaustive tester for a 2-input gate: steps {in1,in2} through 00..11, waits a
// settle time per vector, compares dut_out with the expected function and reports.
module gate_exerciser #(
  parameter int SETTLE_CYCLES = 5,
  parameter int FUNC          = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] mismatch_vec
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] idx;
  logic [1:0] vec;
  logic [7:0] cnt;
  logic       mismatch;
  logic [2:0] err_next;

  function automatic logic expected_out(input logic [1:0] v);
    case (FUNC)
      1:       return v[1] | v[0];
      2:       return v[1] ^ v[0];
      3:       return ~(v[1] & v[0]);
      default: return v[1] & v[0];
    endcase
  endfunction

  assign mismatch = (dut_out != expected_out(vec));
  assign err_next = err_count + {2'b00, mismatch};
  assign busy     = (state == SETTLE) || (state == CHECK);
  assign in1      = vec[1];
  assign in2      = vec[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 2'd0;
      vec          <= 2'd0;
      cnt          <= 8'd0;
      err_count    <= 3'd0;
      mismatch_vec <= 4'd0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= SETTLE;
            idx          <= 2'd0;
            vec          <= 2'd0;
            cnt          <= 8'd0;
            err_count    <= 3'd0;
            mismatch_vec <= 4'd0;
            done         <= 1'b0;
            pass         <= 1'b0;
          end
        end
        SETTLE: begin
          cnt <= cnt + 8'd1;
          if (cnt == SETTLE_LAST) state <= CHECK;
        end
        CHECK: begin
          err_count <= err_next;
          if (mismatch) mismatch_vec[idx] <= 1'b1;
          if (idx != 2'd3) begin
            idx   <= idx + 2'd1;
            vec   <= idx + 2'd1;
            cnt   <= 8'd0;
            state <= SETTLE;
          end else begin
            // pass uses the count including this last vector's result
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_next == 3'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: a behavioural gate model feeds the tester and a
// scoreboard of expected run results is compared when each run reports done.
module tb_gate_exerciser;

  logic clk = 1'b0;
  logic rst, start_a, start_x;
  logic in1_a, in2_a, busy_a, done_a, pass_a;
  logic [2:0] err_a;
  logic [3:0] mv_a;
  logic in1_x, in2_x, busy_x, done_x, pass_x;
  logic [2:0] err_x;
  logic [3:0] mv_x;
  logic dut_out_a, dut_out_x;
  int mode;  // 0 correct AND gate, 1 stuck at 0, 2 stuck at 1

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       pass;
    logic [2:0] err;
    logic [3:0] mvec;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign dut_out_a = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (in1_a & in2_a);
  assign dut_out_x = in1_x & in2_x;

  gate_exerciser #(.SETTLE_CYCLES(5), .FUNC(0)) u_and (
    .clk(clk), .rst(rst), .start(start_a), .dut_out(dut_out_a),
    .in1(in1_a), .in2(in2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .mismatch_vec(mv_a));

  gate_exerciser #(.SETTLE_CYCLES(5), .FUNC(2)) u_xor (
    .clk(clk), .rst(rst), .start(start_x), .dut_out(dut_out_x),
    .in1(in1_x), .in2(in2_x), .busy(busy_x), .done(done_x), .pass(pass_x),
    .err_count(err_x), .mismatch_vec(mv_x));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_func(input int f, input logic [1:0] v);
    case (f)
      1: return v[1] | v[0];
      2: return v[1] ^ v[0];
      3: return ~(v[1] & v[0]);
      default: return v[1] & v[0];
    endcase
  endfunction

  function automatic logic gate_model(input int m, input logic [1:0] v);
    if (m == 1) return 1'b0;
    if (m == 2) return 1'b1;
    return v[1] & v[0];
  endfunction

  task automatic push_exp(input int f, input int m);
    exp_t e;
    e.err  = 3'd0;
    e.mvec = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (gate_model(m, 2'(i)) != ref_func(f, 2'(i))) begin
        e.mvec[i] = 1'b1;
        e.err     = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 3'd0);
    sb.push_back(e);
  endtask

  // Starts a run and observes it until done; optionally pulses start again at
  // cycle pulse_at. Returns latency (-1 on timeout) and the vector sequence.
  task automatic run_obs(input bit x, input int m, input int pulse_at,
                         output int lat, output logic p, output logic [2:0] e,
                         output logic [3:0] mv, output logic [7:0] seq,
                         output int nvec);
    logic [1:0] last, cur;
    mode = m;
    if (x) start_x = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0; start_x = 1'b0;
    last = x ? {in1_x, in2_x} : {in1_a, in2_a};
    seq  = {6'd0, last};
    nvec = 1;
    lat  = -1;
    for (int k = 1; k <= 200; k++) begin
      if (k == pulse_at) begin
        if (x) start_x = 1'b1; else start_a = 1'b1;
      end
      tick();
      start_a = 1'b0; start_x = 1'b0;
      cur = x ? {in1_x, in2_x} : {in1_a, in2_a};
      if (cur != last) begin
        seq  = {seq[5:0], cur};
        nvec++;
        last = cur;
      end
      if (x ? done_x : done_a) begin
        lat = k;
        break;
      end
    end
    p  = x ? pass_x : pass_a;
    e  = x ? err_x : err_a;
    mv = x ? mv_x : mv_a;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b1; start_x = 1'b1;
    tick(); tick();
    rst = 1'b0; start_a = 1'b0; start_x = 1'b0;
    n_checks++;
    if ({in1_a, in2_a, busy_a, done_a, pass_a, err_a, mv_a} !== 12'd0) begin
      n_fail++; $display("FAIL reset_and outputs=%b required=0", {in1_a, in2_a, busy_a, done_a, pass_a, err_a, mv_a});
    end
    n_checks++;
    if ({in1_x, in2_x, busy_x, done_x, pass_x, err_x, mv_x} !== 12'd0) begin
      n_fail++; $display("FAIL reset_xor outputs=%b required=0", {in1_x, in2_x, busy_x, done_x, pass_x, err_x, mv_x});
    end
    tick(); tick();
    n_checks++;
    if ({in1_a, in2_a, busy_a, done_a, pass_a, err_a, mv_a} !== 12'd0) begin
      n_fail++; $display("FAIL idle_hold outputs=%b required=0", {in1_a, in2_a, busy_a, done_a, pass_a, err_a, mv_a});
    end
  endtask

  task automatic test_run(input string name, input bit x, input int f, input int m);
    int lat, nv;
    logic p;
    logic [2:0] e;
    logic [3:0] mv;
    logic [7:0] seq;
    exp_t ex;
    push_exp(f, m);
    run_obs(x, m, 0, lat, p, e, mv, seq, nv);
    ex = sb.pop_front();
    n_checks++;
    if (lat !== 24) begin n_fail++; $display("FAIL %s latency got=%0d required=24", name, lat); end
    n_checks++;
    if (p !== ex.pass) begin n_fail++; $display("FAIL %s pass got=%b required=%b", name, p, ex.pass); end
    n_checks++;
    if (e !== ex.err) begin n_fail++; $display("FAIL %s err_count got=%0d required=%0d", name, e, ex.err); end
    n_checks++;
    if (mv !== ex.mvec) begin n_fail++; $display("FAIL %s mismatch_vec got=%b required=%b", name, mv, ex.mvec); end
    n_checks++;
    if (seq !== 8'b00_01_10_11 || nv !== 4) begin
      n_fail++; $display("FAIL %s vector_order got=%b (%0d vectors) required=00011011", name, seq, nv);
    end
    n_checks++;
    if ((x ? busy_x : busy_a) !== 1'b0) begin n_fail++; $display("FAIL %s busy_in_done got=1 required=0", name); end
    tick(); tick();
    n_checks++;
    if ((x ? {done_x, in1_x, in2_x, err_x, mv_x} : {done_a, in1_a, in2_a, err_a, mv_a}) !== {3'b111, ex.err, ex.mvec}) begin
      n_fail++; $display("FAIL %s done_hold got=%b required=%b", name,
        x ? {done_x, in1_x, in2_x, err_x, mv_x} : {done_a, in1_a, in2_a, err_a, mv_a}, {3'b111, ex.err, ex.mvec});
    end
  endtask

  task automatic test_reset_mid_run();
    int guard = 0;
    mode = 0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    while ({in1_a, in2_a} != 2'b10 && guard < 60) begin tick(); guard++; end
    tick();
    n_checks++;
    if (busy_a !== 1'b1 || {in1_a, in2_a} !== 2'b10) begin
      n_fail++; $display("FAIL midrun_reach busy=%b vec=%b required busy=1 vec=10", busy_a, {in1_a, in2_a});
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if ({in1_a, in2_a, busy_a, done_a, pass_a, err_a, mv_a} !== 12'd0) begin
      n_fail++; $display("FAIL midrun_reset outputs=%b required=0", {in1_a, in2_a, busy_a, done_a, pass_a, err_a, mv_a});
    end
    repeat (30) tick();
    n_checks++;
    if ({busy_a, done_a} !== 2'b00) begin
      n_fail++; $display("FAIL midrun_no_restart busy/done=%b required=00", {busy_a, done_a});
    end
    test_run("after_reset", 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int lat, nv;
    logic p;
    logic [2:0] e;
    logic [3:0] mv;
    logic [7:0] seq;
    exp_t ex;
    push_exp(0, 1);
    run_obs(1'b0, 1, 10, lat, p, e, mv, seq, nv);
    ex = sb.pop_front();
    n_checks++;
    if (lat !== 24) begin n_fail++; $display("FAIL busy_start latency got=%0d required=24", lat); end
    n_checks++;
    if ({p, e, mv} !== {ex.pass, ex.err, ex.mvec}) begin
      n_fail++; $display("FAIL busy_start result got=%b required=%b", {p, e, mv}, {ex.pass, ex.err, ex.mvec});
    end
    // restart from DONE with a correct gate
    mode = 0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_checks++;
    if ({done_a, pass_a, in1_a, in2_a, err_a, mv_a, busy_a} !== 12'b000000000001) begin
      n_fail++; $display("FAIL restart_done got=%b required=000000000001", {done_a, pass_a, in1_a, in2_a, err_a, mv_a, busy_a});
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_x = 1'b0; mode = 0;
    test_reset();
    test_run("and_correct", 1'b0, 0, 0);
    test_run("stuck0", 1'b0, 0, 1);
    test_run("stuck1", 1'b0, 0, 2);
    test_run("xor_expected", 1'b1, 2, 0);
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_exerciser.md
GATE_EXERCISER -- requirements
Module: gate_exerciser

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 5, cycles each input vector is held before the output is sampled (legal range 1..255).
REQ-002 Parameter: FUNC, default 0, expected 2-input function (0=AND, 1=OR, 2=XOR, 3=NAND).
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin a test run when sampled high in IDLE or DONE.
REQ-006 dut_out  input  1  output of the gate under test.
REQ-007 in1  output  1  MSB of the applied input vector, registered.
REQ-008 in2  output  1  LSB of the applied input vector, registered.
REQ-009 busy  output  1  high while a run is in progress (SETTLE or CHECK).
REQ-010 done  output  1  high in DONE, held until start or rst.
REQ-011 pass  output  1  high in DONE when err_count==0, otherwise low.
REQ-012 err_count  output  3  number of mismatching vectors in the current or last run (0..4).
REQ-013 mismatch_vec  output  4  bit i set when vector {in1,in2}==i mismatched.

Function
REQ-014 The FSM SHALL have the states IDLE, SETTLE, CHECK and DONE, with IDLE as the reset state.
REQ-015 IDLE or DONE with start=1 at an edge SHALL load idx=0, {in1,in2}=2'b00, settle counter=0, err_count=0 and mismatch_vec=0, clear done and pass, and go to SETTLE.
REQ-016 SETTLE SHALL increment the settle counter each cycle and go to CHECK at the edge where counter==SETTLE_CYCLES-1, so each vector is held exactly SETTLE_CYCLES cycles.
REQ-017 CHECK (one cycle) SHALL compare dut_out with expected=FUNC({in1,in2}); on mismatch it increments err_count and sets mismatch_vec[idx].
REQ-018 CHECK with idx<3 SHALL increment idx, drive {in1,in2}=idx+1, clear the settle counter and return to SETTLE.
REQ-019 CHECK with idx==3 SHALL go to DONE, with done=1 and pass=(final err_count==0) visible in the first DONE cycle.
REQ-020 Vector order SHALL be 00, 01, 10, 11, with no wrap-around or repeat within a run.
REQ-021 Latency: if start is sampled at edge E0, done SHALL rise at edge E0+4*(SETTLE_CYCLES+1) (24 cycles for the default).
REQ-022 start while busy SHALL be ignored, with no restart and no effect on the counters.
REQ-023 start in DONE SHALL restart the run per REQ-015, and done SHALL drop at that same edge.
REQ-024 In DONE, in1/in2 SHALL hold 2'b11 and err_count/mismatch_vec SHALL hold their values.
REQ-025 err_count SHALL never exceed 4, and 3 bits are sufficient, so no saturation logic is required.
REQ-026 busy SHALL equal (state==SETTLE || state==CHECK), decoded from the registered state.

Reset
REQ-027 rst=1 at an edge SHALL force state=IDLE and in1, in2, busy, done, pass, err_count, mismatch_vec, idx and the settle counter all to 0, taking priority over start.
REQ-028 rst asserted mid-run (any state) SHALL abort the run with no partial result retained, and a new start is required afterwards.
REQ-029 In IDLE after reset, outputs SHALL stay at 0 until start.

Verification
REQ-030 Correct AND gate, FUNC=0, SETTLE_CYCLES=5, start pulse: done at +24 cycles, pass=1, err_count=0, mismatch_vec=4'b0000.
REQ-031 dut_out stuck at 0, FUNC=0: pass=0, err_count=1, mismatch_vec=4'b1000.
REQ-032 dut_out stuck at 1, FUNC=0: pass=0, err_count=3, mismatch_vec=4'b0111.
REQ-033 Correct AND gate with FUNC=2 (XOR expected): err_count=3, mismatch_vec=4'b1110, pass=0.
REQ-034 rst pulsed during SETTLE of vector 2: the next cycle shows all outputs 0 in IDLE; a following start completes a normal run (pass=1 with a correct gate).
REQ-035 start pulsed again at cycle 10 of a run, then again in DONE: the first pulse has no effect (done still at +24); the second restarts the run (done low, in1/in2=00, counters cleared).
